// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Holds the response-owner encoding, the "no write" strobe value and the
// default starvation limit used by mem_port_arbiter and arb_starve_cnt.
package mem_arb_pkg;

    // Which requester a pending SRAM response belongs to.
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [3:0] WSTRB_NONE         = 4'b0000;
    localparam int         STARVE_LIMIT_DEF   = 4;
    localparam int         STARVE_CNT_W       = 4;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core-side fetch/load-store handshakes and the unified SRAM port.
// Ports: inst_* (fetch request/accept/response), data_* (load/store request/
// accept/response), sram_* (single-port synchronous SRAM, 1-cycle read).
// Modports: slave = arbiter view, master = core + SRAM environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch side
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    // load/store side
    logic              data_req;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    // unified SRAM port
    logic              sram_en;
    logic [3:0]        sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wstrb, data_addr, data_wdata,
        input  sram_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wstrb, data_addr, data_wdata,
        output sram_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of consecutive cycles the fetch requester was denied.
// Ports: clk, reset (sync, active-high), inc (fetch waiting and not granted),
// clr (fetch granted or idle), hit (count has reached LIMIT; registered).
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_Q = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != LIMIT_Q)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoded straight from the register, so hit carries no input logic.
    assign hit = (r_cnt == LIMIT_Q);

endmodule : arb_starve_cnt

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous SRAM between instruction fetch
// and load/store. Zero-cycle accept, response steered back exactly 1 cycle later.
// Ports: clk, reset (sync, active-high), bus (mem_port_arbiter_if.slave).
// Build option: ARB_STARVE_GUARD_EN lets a starved fetch win over data once the
// denied-cycle count reaches STARVE_LIMIT; undefined = strict data priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);

    // Elaboration-time parameter legality.
    if (DATA_W != 32) begin : g_bad_data_w
        $error("mem_port_arbiter: DATA_W must be 32");
    end
    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
    end

    logic              w_grant_inst;
    logic              w_grant_data;
    logic              w_starve_hit;
    logic              w_sram_en;
    logic [3:0]        w_sram_we;
    logic [ADDR_W-1:0] w_sram_addr;
    logic [DATA_W-1:0] w_sram_wdata;

    logic              r_resp_valid;
    owner_e            r_resp_owner;

`ifdef ARB_STARVE_GUARD_EN
    logic w_starve_inc;
    logic w_starve_clr;

    assign w_starve_inc = bus.inst_req & ~w_grant_inst;
    assign w_starve_clr = w_grant_inst | ~bus.inst_req;

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_starve_inc),
        .clr   (w_starve_clr),
        .hit   (w_starve_hit)
    );
`else
    assign w_starve_hit = 1'b0;
`endif

    // Data wins a conflict unless fetch has been starved long enough.
    always_comb begin
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        if (!reset) begin
            if (bus.data_req && !(bus.inst_req && w_starve_hit)) begin
                w_grant_data = 1'b1;
            end else if (bus.inst_req) begin
                w_grant_inst = 1'b1;
            end
        end
    end

    // SRAM port mux; idle port drives zeros rather than a stale requester.
    always_comb begin
        w_sram_we    = WSTRB_NONE;
        w_sram_addr  = '0;
        w_sram_wdata = '0;
        if (w_grant_data) begin
            w_sram_we    = bus.data_wstrb;
            w_sram_addr  = bus.data_addr;
            w_sram_wdata = bus.data_wdata;
        end else if (w_grant_inst) begin
            w_sram_addr  = bus.inst_addr;
        end
    end

    assign w_sram_en = w_grant_inst | w_grant_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_owner <= OWN_INST;
        end else begin
            r_resp_valid <= w_sram_en;
            r_resp_owner <= w_grant_data ? OWN_DATA : OWN_INST;
        end
    end

    assign bus.inst_addr_ok = w_grant_inst;
    assign bus.data_addr_ok = w_grant_data;

    assign bus.sram_en    = w_sram_en;
    assign bus.sram_we    = w_sram_we;
    assign bus.sram_addr  = w_sram_addr;
    assign bus.sram_wdata = w_sram_wdata;

    // A response already registered when reset rises is dropped, not delivered.
    assign bus.inst_data_ok = r_resp_valid & (r_resp_owner == OWN_INST) & ~reset;
    assign bus.data_data_ok = r_resp_valid & (r_resp_owner == OWN_DATA) & ~reset;

    assign bus.inst_rdata = bus.sram_rdata;
    assign bus.data_rdata = bus.sram_rdata;

endmodule : mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing one single-port synchronous SRAM between the CPU's instruction-fetch path and its load/store path. It sits between the core's `inst_sram_*`/`data_sram_*` side and a unified memory. It grants at most one access per cycle and tracks which requester owns each outstanding response. The read-data return is steered back to the correct requester one cycle later.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; must be 32 (4 byte strobes).
- `STARVE_LIMIT`, 4: consecutive denied fetch cycles before fetch is forced ahead of data; legal range 1..15.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous reset, active-high.
- `inst_req` in 1: fetch request valid.
- `inst_addr` in ADDR_W: fetch address.
- `inst_addr_ok` out 1: fetch request accepted this cycle.
- `inst_data_ok` out 1: fetch read data valid.
- `inst_rdata` out DATA_W: fetch read data.
- `data_req` in 1: load/store request valid.
- `data_wstrb` in 4: byte write strobes; 0 means read.
- `data_addr` in ADDR_W: load/store address.
- `data_wdata` in DATA_W: store data.
- `data_addr_ok` out 1: load/store accepted this cycle.
- `data_data_ok` out 1: load data valid or store completed.
- `data_rdata` out DATA_W: load data.
- `sram_en` out 1: SRAM access enable.
- `sram_we` out 4: SRAM byte write enables.
- `sram_addr` out ADDR_W: SRAM address.
- `sram_wdata` out DATA_W: SRAM write data.
- `sram_rdata` in DATA_W: SRAM read data, valid one cycle after `sram_en`.

## Operation
- Grant decision is combinational each cycle: `grant_inst`, `grant_data`, mutually exclusive.
  - Only one requester active → grant it.
  - Both active → grant data, unless the starvation guard fires (see Configuration); then grant inst.
- `*_addr_ok` equals its grant.
- The SRAM port is driven from the granted requester.
  - `sram_en` = `grant_inst | grant_data`.
  - `sram_we` = `data_wstrb` when data is granted, else 0.
  - With no grant: `sram_addr` and `sram_wdata` are 0.
- Response tracking uses two registers:
  - `resp_valid` ← `sram_en`.
  - `resp_owner` ← data (1) / inst (0) of the granted requester.
- `inst_data_ok` = `resp_valid & ~resp_owner`; `data_data_ok` = `resp_valid & resp_owner`.
- `inst_rdata` and `data_rdata` both carry `sram_rdata` directly. Each is meaningful only with its own `data_ok`.
- Stores also produce `data_data_ok` one cycle after acceptance; `data_rdata` is don't-care for stores.
- Requesters may hold `req` high across cycles. A new request can be accepted every cycle, so back-to-back accepts are fully pipelined.
- Requesters must keep `req`/`addr`/`wdata`/`wstrb` stable until `addr_ok`.

## Timing
- Accept latency is 0 cycles: `addr_ok` arrives in the same cycle as `req` when granted.
- Response latency is exactly 1 cycle after accept. Throughput is 1 access per cycle in total.
- Reset values:
  - `resp_valid`=0, `resp_owner`=0, starve counter=0.
  - Therefore `inst_data_ok`=0 and `data_data_ok`=0.
- While `reset`=1, both grants, both `addr_ok`, `sram_en` and `sram_we` are forced to 0.
- Reset in the cycle after an accept discards the pending response. No `data_ok` is produced for it.
- Simultaneous requests with no starvation get the data grant. The fetch `addr_ok`=0 and fetch retries the next cycle.
- Starve counter, width 4 bits:
  - Increments when `inst_req & ~grant_inst`, saturating at `STARVE_LIMIT`.
  - Clears on `grant_inst` or `~inst_req`.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: when counter == `STARVE_LIMIT` and both requesters are active, inst is granted and data waits one cycle.
- `ARB_STARVE_GUARD_EN` undefined:
  - Strict data priority.
  - Counter logic is absent; fetch can starve indefinitely under continuous `data_req`.

## Structure
- Shared package `mem_arb_pkg` holds:
  - Owner encoding `OWN_INST`=1'b0, `OWN_DATA`=1'b1.
  - Strobe constant `WSTRB_NONE`=4'b0000.
  - Default `STARVE_LIMIT`.
- One sub-module, `arb_starve_cnt`: the saturating counter with inputs `clk`, `reset`, `inc`, `clr` and output `hit`. It is instantiated only under `ARB_STARVE_GUARD_EN`.

## Test plan
- **Fetch only:** `inst_req`=1, `inst_addr`=0x1c000000 with SRAM word 0x02800421.
  - Expect `inst_addr_ok`=1 that cycle.
  - Expect `inst_data_ok`=1 and `inst_rdata`=0x02800421 the next cycle.
- **Store then load:**
  - Store: `data_wstrb`=4'hf, addr 0x100, wdata 0xdeadbeef. Expect `sram_we`=4'hf and `data_data_ok`=1 one cycle later.
  - Load from 0x100 next. Expect `data_rdata`=0xdeadbeef with `data_data_ok`.
- **Conflict:** `inst_req`=`data_req`=1 for one cycle.
  - Expect `data_addr_ok`=1 and `inst_addr_ok`=0.
  - Next cycle `inst_addr_ok`=1. Owner routing is correct for both responses.
- **Starvation, guard on, `STARVE_LIMIT`=4:** both requests held high.
  - Data is granted in cycles 0–3.
  - Cycle 4 grants inst, then the counter clears.
  - With the macro off, inst is never granted over 20 cycles.
- **Reset mid-flight:** accept a fetch, then assert `reset` the next cycle.
  - Expect no `inst_data_ok` and `sram_en`=0 during reset.
  - All `data_ok` outputs are 0 on the first cycle after release.
